// File: rtl/vga_timing_generator.sv
// Raster timing for a VGA display: pixel-rate divider, h/v counters, and a
// one-pixel-deep output register that aligns colour, syncs and active.
module vga_timing_generator #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] x,
  output logic [10:0] y,
  input  logic [2:0]  r,
  input  logic [2:0]  g,
  input  logic [2:0]  b,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [2:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [1:0]  DIV_LAST  = 2'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYN_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYN_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYN_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYN_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  function automatic logic syncLevel(input logic inPulse);
    return inPulse ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic [8:0] blankRgb(input logic vis, input logic [8:0] rgb);
    return vis ? rgb : 9'd0;
  endfunction

  logic [1:0]  div;
  logic        pe;
  logic [10:0] hCount;
  logic [10:0] vCount;
  logic        hLast;
  logic        vLast;
  logic        vis;
  logic        hPulse;
  logic        vPulse;

  // With CLK_DIV=1 DIV_LAST is 0, so div never leaves 0 and pe stays high.
  assign pe     = (div == DIV_LAST);
  assign hLast  = (hCount == H_LAST);
  assign vLast  = (vCount == V_LAST);
  assign vis    = (hCount < H_VIS_END) && (vCount < V_VIS_END);
  assign hPulse = (hCount >= H_SYN_BEG) && (hCount < H_SYN_END);
  assign vPulse = (vCount >= V_SYN_BEG) && (vCount < V_SYN_END);

  assign x = hCount;
  assign y = vCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= 2'd0;
    end else if (pe) begin
      div <= 2'd0;
    end else begin
      div <= div + 2'd1;
    end
  end

  // Stage p0: raster counters, advancing once per pixel period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= 11'd0;
      vCount <= 11'd0;
    end else if (pe) begin
      if (hLast) begin
        hCount <= 11'd0;
        vCount <= vLast ? 11'd0 : vCount + 11'd1;
      end else begin
        hCount <= hCount + 11'd1;
      end
    end
  end

  // Stage p1: everything derived from one (x,y) loads together on the same pe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 9'd0;
      hsync                 <= ~SYNC_POL;
      vsync                 <= ~SYNC_POL;
      active                <= 1'b0;
      frame_start           <= 1'b0;
    end else begin
      frame_start <= pe && hLast && vLast;
      if (pe) begin
        {vga_r, vga_g, vga_b} <= blankRgb(vis, {r, g, b});
        hsync                 <= syncLevel(hPulse);
        vsync                 <= syncLevel(vPulse);
        active                <= vis;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: two reduced-geometry builds (CLK_DIV=2 and 1)
// checked each cycle against a pixel-index model, plus literal timing pins.
module tb_vga_timing_generator;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 8
  localparam bit POL = 1'b0;

  typedef struct packed {
    logic [10:0] x, y;
    logic [2:0]  r, g, b;
    logic        hs, vs, act, fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  int   n;
  int   tests = 0;
  int   fails = 0;

  logic [10:0] x2, y2, x1, y1;
  logic [2:0]  r2, g2, b2, r1, g1, b1;
  logic [2:0]  vr2, vg2, vb2, vr1, vg1, vb1;
  logic        hs2, vs2, act2, fs2, hs1, vs1, act1, fs1;

  always #5 clk = ~clk;

  assign r2 = mode ? 3'd7 : x2[2:0];
  assign g2 = mode ? 3'd7 : y2[2:0];
  assign b2 = mode ? 3'd7 : (x2[2:0] ^ y2[2:0]);
  assign r1 = mode ? 3'd7 : x1[2:0];
  assign g1 = mode ? 3'd7 : y1[2:0];
  assign b1 = mode ? 3'd7 : (x1[2:0] ^ y1[2:0]);

  vga_timing_generator #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)) dut2 (
    .clk(clk), .rst(rst), .x(x2), .y(y2), .r(r2), .g(g2), .b(b2),
    .vga_r(vr2), .vga_g(vg2), .vga_b(vb2), .hsync(hs2), .vsync(vs2),
    .active(act2), .frame_start(fs2));

  vga_timing_generator #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)) dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .r(r1), .g(g1), .b(b1),
    .vga_r(vr1), .vga_g(vg1), .vga_b(vb1), .hsync(hs1), .vsync(vs1),
    .active(act1), .frame_start(fs1));

  // Clock edges seen since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // After n edges, floor(n/d) pixels have elapsed; outputs show the pixel before that.
  function automatic exp_t model(input int edges, input int d, input logic md, input logic inRst);
    exp_t e;
    int p, q, qx, qy;
    logic vis;
    e = '0;
    e.hs = ~POL;
    e.vs = ~POL;
    if (!inRst) begin
      p   = edges / d;
      e.x = 11'(p % HT);
      e.y = 11'((p / HT) % VT);
      if (p >= 1) begin
        q   = p - 1;
        qx  = q % HT;
        qy  = (q / HT) % VT;
        vis = (qx < HV) && (qy < VV);
        e.act = vis;
        if (vis) begin
          e.r = md ? 3'd7 : 3'(qx & 7);
          e.g = md ? 3'd7 : 3'(qy & 7);
          e.b = md ? 3'd7 : 3'((qx ^ qy) & 7);
        end
        e.hs = (qx >= HV + HF && qx < HV + HF + HS) ? POL : ~POL;
        e.vs = (qy >= VV + VF && qy < VV + VF + VS) ? POL : ~POL;
        e.fs = (edges % d == 0) && (q % (HT * VT) == HT * VT - 1);
      end
    end
    return e;
  endfunction

  exp_t e2, e1;
  always @(negedge clk) begin
    e2 = model(n, 2, mode, rst);
    e1 = model(n, 1, mode, rst);
    chk("d2.x", int'(x2), int'(e2.x));     chk("d1.x", int'(x1), int'(e1.x));
    chk("d2.y", int'(y2), int'(e2.y));     chk("d1.y", int'(y1), int'(e1.y));
    chk("d2.vga_r", int'(vr2), int'(e2.r)); chk("d1.vga_r", int'(vr1), int'(e1.r));
    chk("d2.vga_g", int'(vg2), int'(e2.g)); chk("d1.vga_g", int'(vg1), int'(e1.g));
    chk("d2.vga_b", int'(vb2), int'(e2.b)); chk("d1.vga_b", int'(vb1), int'(e1.b));
    chk("d2.hsync", int'(hs2), int'(e2.hs)); chk("d1.hsync", int'(hs1), int'(e1.hs));
    chk("d2.vsync", int'(vs2), int'(e2.vs)); chk("d1.vsync", int'(vs1), int'(e1.vs));
    chk("d2.active", int'(act2), int'(e2.act)); chk("d1.active", int'(act1), int'(e1.act));
    chk("d2.frame_start", int'(fs2), int'(e2.fs)); chk("d1.frame_start", int'(fs1), int'(e1.fs));
  end

  // Edge/run recorders for the literal timing pins.
  int hsRun, vsRun;
  logic prevHs, prevVs;
  int hsFalls[$], hsRuns[$], vsFalls[$], vsRuns[$], fs2At[$], fs1At[$];
  always @(negedge clk) begin
    if (rst) begin
      hsRun <= 0; vsRun <= 0; prevHs <= 1'b1; prevVs <= 1'b1;
    end else begin
      hsRun <= hs2 ? 0 : hsRun + 1;
      vsRun <= vs2 ? 0 : vsRun + 1;
      if (!hs2 && prevHs) hsFalls.push_back(n);
      if (hs2 && !prevHs) hsRuns.push_back(hsRun);
      if (!vs2 && prevVs) vsFalls.push_back(n);
      if (vs2 && !prevVs) vsRuns.push_back(vsRun);
      if (fs2) fs2At.push_back(n);
      if (fs1) fs1At.push_back(n);
      prevHs <= hs2;
      prevVs <= vs2;
    end
  end

  function automatic int at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("release.x", int'(x2), 0);
    chk("release.hsync", int'(hs2), 1);
    chk("release.vsync", int'(vs2), 1);
    chk("release.active", int'(act2), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("first_pe.x_div2", int'(x2), 1);
    chk("first_pe.x_div1", int'(x1), 2);

    repeat (400) @(posedge clk);
    #1;
    chk("hsync.first_fall_clk", at(hsFalls, 0), 22);
    chk("hsync.period_clk", at(hsFalls, 1) - at(hsFalls, 0), 30);
    chk("hsync.width_clk", at(hsRuns, 0), 6);
    chk("vsync.first_fall_clk", at(vsFalls, 0), 152);
    chk("vsync.width_clk", at(vsRuns, 0), 60);
    chk("frame_start.first_div2", at(fs2At, 0), 240);
    chk("frame_start.first_div1", at(fs1At, 0), 120);
    chk("frame_start.period_div1", at(fs1At, 1) - at(fs1At, 0), 120);

    // Mid-frame asynchronous reset, then a solid-white renderer.
    repeat (37) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.x", int'(x2), 0);
    chk("async_rst.y", int'(y2), 0);
    chk("async_rst.vga_r", int'(vr2), 0);
    chk("async_rst.hsync", int'(hs1), 1);
    mode = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
